// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single register-file write port.
// Supports bounded locked bursts and keeps a saturating contention counter.
module regfile_write_arbiter #(
  parameter int N_REQ    = 4,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 16,
  parameter int LOCK_MAX = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ-1:0]          req_lock,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      WE,
  output logic [ADDR_W-1:0]         RegAdd,
  output logic [DATA_W-1:0]         WD,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic [7:0]                conflict_cnt
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam logic [IDX_W:0]   N_REQ_W    = (IDX_W+1)'(N_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_REQ - 1);
  localparam logic [7:0]       LOCK_MAX_W = 8'(LOCK_MAX);

  typedef enum logic {ARB, LOCKED} state_t;

  state_t            state_reg, state_next;
  logic [IDX_W-1:0]  ptr_reg, ptr_next;
  logic [IDX_W-1:0]  owner_reg, owner_next;
  logic [7:0]        lock_cnt_reg, lock_cnt_next;
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] data_reg;
  logic [IDX_W-1:0]  grant_reg;
  logic [7:0]        conflict_reg;

  logic [ADDR_W-1:0] addr_arr [N_REQ];
  logic [DATA_W-1:0] data_arr [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
      assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Rotating priority search: first valid requester at or after ptr, wrapping.
  logic             arb_found;
  logic [IDX_W-1:0] arb_idx;
  logic [IDX_W:0]   cand_sum;

  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand_sum  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_sum = {1'b0, ptr_reg} + (IDX_W+1)'(k);
      if (cand_sum >= N_REQ_W) cand_sum = cand_sum - N_REQ_W;
      if (!arb_found && req_valid[cand_sum[IDX_W-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = cand_sum[IDX_W-1:0];
      end
    end
  end

  logic             xfer;
  logic [IDX_W-1:0] sel_idx;

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    owner_next    = owner_reg;
    lock_cnt_next = lock_cnt_reg;
    req_ready     = '0;
    sel_idx       = owner_reg;
    xfer          = 1'b0;
    if (rst_n) begin
      if (state_reg == ARB) begin
        if (arb_found) begin
          req_ready[arb_idx] = 1'b1;
          sel_idx  = arb_idx;
          xfer     = 1'b1;
          ptr_next = (arb_idx == LAST_IDX) ? '0 : arb_idx + IDX_W'(1);
          // With LOCK_MAX of 1 the first grant already exhausts the burst.
          if (req_lock[arb_idx] && (LOCK_MAX > 1)) begin
            state_next    = LOCKED;
            owner_next    = arb_idx;
            lock_cnt_next = 8'd1;
          end
        end
      end else begin
        if (req_valid[owner_reg]) begin
          req_ready[owner_reg] = 1'b1;
          xfer          = 1'b1;
          lock_cnt_next = lock_cnt_reg + 8'd1;
          if (!req_lock[owner_reg] || (lock_cnt_next >= LOCK_MAX_W)) state_next = ARB;
        end else begin
          state_next = ARB;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= ARB;
      ptr_reg      <= '0;
      owner_reg    <= '0;
      lock_cnt_reg <= '0;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      data_reg     <= '0;
      grant_reg    <= '0;
      conflict_reg <= '0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      owner_reg    <= owner_next;
      lock_cnt_reg <= lock_cnt_next;
      we_reg       <= xfer;
      if (xfer) begin
        addr_reg  <= addr_arr[sel_idx];
        data_reg  <= data_arr[sel_idx];
        grant_reg <= sel_idx;
      end
      if (($countones(req_valid) >= 2) && (conflict_reg != 8'hFF))
        conflict_reg <= conflict_reg + 8'd1;
    end
  end

  assign WE           = we_reg;
  assign RegAdd       = addr_reg;
  assign WD           = data_reg;
  assign grant_id     = grant_reg;
  assign conflict_cnt = conflict_reg;

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Round-robin arbiter sharing the single register-file write port among N_REQ requesters (factorization datapath units, load path, host). Each cycle it selects at most one valid request and registers its address and data onto the write port. The port drives the 4-to-16 write-enable decoder (`WE`, `RegAdd`) and the register-file data input (`WD`). It supports short locked bursts for multi-word results, with a starvation bound, and keeps a saturating contention counter for performance monitoring.

## Interface
- N_REQ, 4, number of requesters (2..8)
- ADDR_W, 4, register address width (matches the 16-entry register file)
- DATA_W, 16, write data width
- LOCK_MAX, 8, maximum consecutive grants under lock (1..255)

- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  N_REQ  per-requester write request
- req_lock  in  N_REQ  requester asks to keep the grant after this transfer
- req_addr  in  N_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_data  in  N_REQ*DATA_W  packed data, requester i at [i*DATA_W +: DATA_W]
- req_ready  out  N_REQ  one-hot or zero; transfer occurs when req_valid[i] & req_ready[i]
- WE  out  1  registered write enable to the decoder and register file
- RegAdd  out  ADDR_W  registered write address
- WD  out  DATA_W  registered write data
- grant_id  out  $clog2(N_REQ)  index of the requester whose write is on the port
- conflict_cnt  out  8  saturating count of cycles with two or more req_valid bits set

## Operation
- States:
  - ARB: normal round-robin.
  - LOCKED: the current owner holds the grant.
- ARB behaviour:
  - Search starts at index ptr and wraps modulo N_REQ. The first i with req_valid[i] gets req_ready[i]=1.
  - On a transfer, ptr becomes (i+1) mod N_REQ.
  - If req_lock[i] is also high, go to LOCKED with owner=i and lock_cnt=1.
- LOCKED behaviour:
  - req_ready[owner] = req_valid[owner]. All other ready bits are 0.
  - Each transfer increments lock_cnt.
  - Return to ARB when any of these holds:
    - the owner's transfer has req_lock low;
    - req_valid[owner] is low in a cycle (no transfer that cycle, and the grant is released immediately);
    - lock_cnt reaches LOCK_MAX on a transfer.
  - ptr stays at owner+1 throughout the lock.
- req_ready is combinational from state, ptr and req_valid. req_valid must not depend combinationally on req_ready.
- Requester ordering: a requester's address and data must stay stable while its valid is high and its ready is low.
- Multiple requesters targeting the same address in consecutive cycles are written in grant order; the last write wins. No merging or address checking.
- conflict_cnt increments whenever popcount(req_valid) ≥ 2, in any state. It saturates at 255.

## Timing
- Latency is exactly 1 cycle: a transfer at edge t gives WE=1 with the matching RegAdd, WD and grant_id during cycle t+1.
- Throughput is one write per cycle. Back-to-back grants to different requesters need no bubble.
- In a cycle with no transfer, WE=0. RegAdd, WD and grant_id hold their previous values.
- Reset (rst_n low at a rising edge) sets:
  - WE=0, RegAdd=0, WD=0, grant_id=0;
  - ptr=0, state ARB, lock_cnt=0, conflict_cnt=0.
  - req_ready=0 while rst_n is low.
- Reset mid-burst drops the lock. A transfer presented in the reset cycle is not accepted and produces no write.
- lock_cnt is 8 bits. LOCK_MAX=1 makes req_lock have no effect.

## Test plan
- Single request: after reset, req_valid=4'b0100, addr 4'd9, data 16'hBEEF. req_ready=4'b0100 in cycle t. In t+1: WE=1, RegAdd=9, WD=16'hBEEF, grant_id=2. Then WE=0.
- Round-robin: all four valid continuously for 8 cycles. Grant order is 0,1,2,3,0,1,2,3 with WE high every cycle. conflict_cnt=8.
- Lock burst: requester 1 valid with req_lock for 3 transfers, then req_lock low on the 4th; requester 3 also valid throughout. Grants are 1,1,1,1 then 3.
- Starvation bound: requester 0 holds req_lock and valid permanently; requester 2 is valid. Exactly 8 consecutive grants to 0, then grant to 2, then 0 is eligible again by round-robin.
- Mid-lock release and reset: owner drops valid in the middle of a lock; the next cycle another requester is granted. Separately, assert rst_n=0 during a burst: the next cycle shows WE=0, ptr=0 and state ARB, and a fresh request from requester 3 is granted.
- Saturation: hold two requesters valid for 300 cycles. conflict_cnt stops at 255.
